alu_mdu_sequencer: RTL and testbench
====================================

Name: alu_mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer that drives the core's existing 32-bit ALU to execute MUL, MULHU, DIVU and REMU (RV32M unsigned subset).
- Shift-add multiply and restoring divide run one ALU operation per cycle, 32 iterations per instruction.
- Sits beside the ALU. While `alu_req` is high, top level muxes the sequencer's operands and control into the ALU in place of the decoder's.
- Start/busy/done handshake to the core stall logic.

Parameters:
- XLEN, 32, operand/result width; only 32 supported.
- ITER_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU
- opa  input  32  multiplicand / dividend
- opb  input  32  multiplier / divisor
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  32  registered result, held until next accepted start
- alu_req  output  1  sequencer owns ALU (RUN state)
- alu_a  output  32  ALU operand a
- alu_b  output  32  ALU operand b
- alu_control  output  3  000 add, 001 sub
- alu_result  input  32  ALU result
- alu_c  input  1  ALU carry-out (add carry; sub: 1 = no borrow)

Behaviour:
- Reset (async, rst low): state IDLE; busy=0, done=0, result=0, alu_req=0, alu_a=alu_b=0, alu_control=000; internal hi/lo/count cleared.
- Reset mid-operation aborts; no done pulse is issued.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 latches op, opa, opb; hi=0; lo=opa (div) or opb (mul); count=0; goes to RUN.
  - start while busy is ignored and not queued.
- RUN: 32 cycles (count 0..31). alu_req=1; ALU outputs are combinational from registers.
- MUL/MULHU iteration:
  - alu_a=hi, alu_b=lo[0]?mcand:0, alu_control=000.
  - {hi,lo} <= {alu_c, alu_result, lo} >> 1, i.e. hi <= {alu_c, alu_result[31:1]}, lo <= {alu_result[0], lo[31:1]}.
- DIVU/REMU iteration:
  - sh = {hi[30:0], lo[31]}; alu_a=sh, alu_b=divisor, alu_control=001.
  - take = hi[31] | alu_c.
  - hi <= take ? alu_result : sh; lo <= {lo[30:0], take}.
- On count=31: go to DONE; result <= lo (MUL, DIVU) or hi (MULHU, REMU), using the final-iteration values.
- DONE: one cycle, done=1, busy=1, alu_req=0. Next cycle IDLE; start is accepted from then on.
- Latency: start edge E0; done high in cycle 33 after E0; busy high cycles 1..33; earliest next accept at edge E34.
- Divide by zero needs no special case: the algorithm yields quotient 0xFFFFFFFF and remainder = dividend (RISC-V compliant).
- Arithmetic is modulo 2^32. The 33rd remainder bit is carried in hi[31] before the shift, which makes divisors >= 0x80000000 correct.
- alu_a, alu_b and alu_control are 0/000 whenever not in RUN.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: from IDLE, MUL/MULHU with opa=0 or opb=0, or DIVU/REMU with opb=0, skips RUN and goes to DONE directly.
  - done is high in cycle 1 after E0.
  - Results: mul=0; DIVU=0xFFFFFFFF; REMU=opa.
  - alu_req stays 0.
- Undefined: every operation takes the full 32 iterations; results are identical.

Test Plan:
- MUL opa=7, opb=6 -> done at cycle 33, result=0x0000002A; alu_req high exactly cycles 1..32.
- MULHU opa=opb=0xFFFFFFFF -> result=0xFFFFFFFE; MUL with same operands -> 0x00000001.
- DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002; DIVU 0xFFFFFFFF/0x80000001 -> 1; REMU same operands -> 0x7FFFFFFE.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
  - Without MDU_EARLY_OUT_EN: done at cycle 33.
  - With it: done at cycle 1.
- start held high during RUN with different operands -> ignored; first result unchanged; second op accepted only at edge E34.
- rst low at cycle 10 of a DIVU -> busy, done and result go to 0 immediately; no done pulse; a new MUL 3*5 after release returns 0x0000000F.

Source files
------------

// File: rtl/alu_mdu_sequencer.sv
// Multi-cycle MUL/MULHU/DIVU/REMU sequencer that borrows the core's 32-bit ALU
// for one add/sub per cycle. Optional zero-operand early-out: MDU_EARLY_OUT_EN.
module alu_mdu_sequencer #(
  parameter int XLEN   = 32,
  parameter int ITER_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_c
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULHU = 2'b01,
                            OP_DIVU = 2'b10, OP_REMU = 2'b11} mdu_op_e;

  localparam logic [2:0]        ALU_ADD  = 3'b000;
  localparam logic [2:0]        ALU_SUB  = 3'b001;
  localparam logic [ITER_W-1:0] LAST_IT  = ITER_W'(XLEN - 1);

  state_e            state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [ITER_W-1:0] count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   sh;
  logic              take;
`ifdef MDU_EARLY_OUT_EN
  logic              early;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    count_d     = count_q;
    result_d    = result_q;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    sh          = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    take        = 1'b0;
`ifdef MDU_EARLY_OUT_EN
    early       = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = mdu_op_e'(op);
          opnd_d  = op[1] ? opb : opa;
          hi_d    = '0;
          lo_d    = op[1] ? opa : opb;
          count_d = '0;
          state_d = S_RUN;
`ifdef MDU_EARLY_OUT_EN
          early = op[1] ? (opb == '0) : ((opa == '0) || (opb == '0));
          if (early) begin
            state_d = S_DONE;
            unique case (mdu_op_e'(op))
              OP_DIVU: result_d = '1;
              OP_REMU: result_d = opa;
              default: result_d = '0;
            endcase
          end
`endif
        end
      end

      S_RUN: begin
        if (op_q[1]) begin
          // Restoring divide; hi[31] is the 33rd remainder bit shifted out.
          alu_a       = sh;
          alu_b       = opnd_q;
          alu_control = ALU_SUB;
          take        = hi_q[XLEN-1] | alu_c;
          hi_d        = take ? alu_result : sh;
          lo_d        = {lo_q[XLEN-2:0], take};
        end else begin
          alu_a       = hi_q;
          alu_b       = lo_q[0] ? opnd_q : '0;
          alu_control = ALU_ADD;
          hi_d        = {alu_c, alu_result[XLEN-1:1]};
          lo_d        = {alu_result[0], lo_q[XLEN-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == LAST_IT) begin
          state_d  = S_DONE;
          result_d = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? lo_d : hi_d;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign alu_req = (state_q == S_RUN);
  assign result  = result_q;

endmodule

// File: tb/tb_alu_mdu_sequencer.sv
// Directed bench for alu_mdu_sequencer with a behavioural add/sub ALU model.
// Expected early-out latencies follow MDU_EARLY_OUT_EN when it is defined.
module tb_alu_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic        busy, done, alu_req, alu_c;
  logic [31:0] result, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_mdu_sequencer #(.XLEN(32), .ITER_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .alu_req(alu_req),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_c(alu_c)
  );

  // Reference ALU: sub carry-out is 1 when no borrow occurs.
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_control)
      3'b000:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      3'b001:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: alu_sum = '0;
    endcase
  end
  assign alu_result = alu_sum[31:0];
  assign alu_c      = alu_sum[32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op and watches up to 40 cycles for done (cycle k = k-th negedge after E0).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int exp_req, input logic [2:0] exp_ctrl);
    int done_at, req_cnt, req_first;
    logic [2:0] ctrl_seen;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1 start = 1'b0;
    done_at = 0; req_cnt = 0; req_first = 0; ctrl_seen = 3'b111;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      if (alu_req) begin
        req_cnt++;
        if (req_first == 0) begin
          req_first = k;
          ctrl_seen = alu_control;
        end
      end
      if (done) begin
        done_at = k;
        check({tag, "_result"}, result, exp_res);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      end
    end
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_lat));
    check({tag, "_alu_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    if (exp_req > 0) begin
      check({tag, "_alu_req_first"}, 32'(req_first), 32'd1);
      check({tag, "_alu_ctrl"}, 32'(ctrl_seen), 32'(exp_ctrl));
    end
    @(negedge clk);
    check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_result_held"}, result, exp_res);
  endtask

`ifdef MDU_EARLY_OUT_EN
  localparam int ZLAT = 1;
  localparam int ZREQ = 0;
`else
  localparam int ZLAT = 33;
  localparam int ZREQ = 32;
`endif

  initial begin
    int first_done, second_done, done_cnt;
    logic [31:0] first_res, second_res;
    logic busy_c34, busy_c35;

    rst = 1'b0; start = 1'b0; op = 2'b00; opa = '0; opb = '0;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu_req", 32'(alu_req), 32'd0);
    check("rst_alu_ab", alu_a | alu_b, 32'd0);
    check("rst_alu_ctrl", 32'(alu_control), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_op("mul_7x6",      2'b00, 32'd7,        32'd6,        32'h0000002A, 33, 32, 3'b000);
    run_op("mulhu_ff",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32, 3'b000);
    run_op("mul_ff",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33, 32, 3'b000);
    run_op("divu_100_7",   2'b10, 32'd100,      32'd7,        32'h0000000E, 33, 32, 3'b001);
    run_op("remu_100_7",   2'b11, 32'd100,      32'd7,        32'h00000002, 33, 32, 3'b001);
    run_op("divu_big",     2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 33, 32, 3'b001);
    run_op("remu_big",     2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33, 32, 3'b001);
    run_op("divu_by0",     2'b10, 32'h00001234, 32'd0,        32'hFFFFFFFF, ZLAT, ZREQ, 3'b001);
    run_op("remu_by0",     2'b11, 32'h00001234, 32'd0,        32'h00001234, ZLAT, ZREQ, 3'b001);
    run_op("mulhu_zero",   2'b01, 32'd0,        32'd5,        32'h00000000, ZLAT, ZREQ, 3'b000);

    // start held high through RUN with different operands: only accepted at E34.
    @(negedge clk);
    start = 1'b1; op = 2'b00; opa = 32'd7; opb = 32'd6;
    @(posedge clk);
    #1 op = 2'b10; opa = 32'd100; opb = 32'd7;
    first_done = 0; second_done = 0; first_res = '0; second_res = '0;
    busy_c34 = 1'b1; busy_c35 = 1'b0;
    for (int k = 1; k <= 80 && second_done == 0; k++) begin
      @(negedge clk);
      if (k == 34) busy_c34 = busy;
      if (k == 35) begin
        busy_c35 = busy;
        start = 1'b0;
      end
      if (done && first_done == 0) begin
        first_done = k; first_res = result;
      end else if (done) begin
        second_done = k; second_res = result;
      end
    end
    check("held_first_cycle", 32'(first_done), 32'd33);
    check("held_first_result", first_res, 32'h0000002A);
    check("held_idle_c34", 32'(busy_c34), 32'd0);
    check("held_accept_c35", 32'(busy_c35), 32'd1);
    check("held_second_cycle", 32'(second_done), 32'd67);
    check("held_second_result", second_res, 32'h0000000E);

    // Reset in the middle of a DIVU aborts without a done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b10; opa = 32'd100; opb = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_alu_req", 32'(alu_req), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000000F, 33, 32, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
